// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: carries decoded control and Rd through the E/M/W stages, handles stall/flush
// bubbles, computes the PC redirect in Execute and counts retired instructions.
module ctrl_pipeline #(
  parameter int RD_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic [3:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic [1:0]       MemStrobeD,
  input  logic [RD_W-1:0]  RdD,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             BranchTakenE,
  output logic [3:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic [1:0]       ResultSrcE,
  output logic [RD_W-1:0]  RdE,
  output logic             PCSrcE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       MemStrobeM,
  output logic [1:0]       ResultSrcM,
  output logic [RD_W-1:0]  RdM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [RD_W-1:0]  RdW,
  output logic [CNT_W-1:0] RetireCnt
);
  typedef struct packed {
    logic            v;
    logic            rw;
    logic [1:0]      rs;
    logic            mw;
    logic            j;
    logic            b;
    logic [3:0]      alu;
    logic            as;
    logic [1:0]      ms;
    logic [RD_W-1:0] rd;
  } e_t;
  typedef struct packed {
    logic            v;
    logic            rw;
    logic [1:0]      rs;
    logic            mw;
    logic [1:0]      ms;
    logic [RD_W-1:0] rd;
  } m_t;
  typedef struct packed {
    logic            v;
    logic            rw;
    logic [1:0]      rs;
    logic [RD_W-1:0] rd;
  } w_t;
  e_t e_q, e_d, d_in;
  m_t m_q, m_d;
  w_t w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    d_in = '{v: 1'b1, rw: RegWriteD, rs: ResultSrcD, mw: MemWriteD, j: JumpD, b: BranchD,
             alu: ALUControlD, as: ALUSrcD, ms: MemStrobeD, rd: RdD};
    e_d = FlushE ? '0 : StallE ? e_q : ValidD ? d_in : '0;
    // a stalled E instruction must not also advance, so M takes a bubble instead
    m_d = (StallE && !FlushE) ? '0 : '{v: e_q.v, rw: e_q.rw, rs: e_q.rs, mw: e_q.mw, ms: e_q.ms, rd: e_q.rd};
    w_d = '{v: m_q.v, rw: m_q.rw, rs: m_q.rs, rd: m_q.rd};
    cnt_d = cnt_q + CNT_W'(w_q.v);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end
  assign ALUControlE = e_q.alu;
  assign ALUSrcE     = e_q.as;
  assign ResultSrcE  = e_q.rs;
  assign RdE         = e_q.rd;
  assign PCSrcE      = e_q.v & (e_q.j | (e_q.b & BranchTakenE));
  assign RegWriteM   = m_q.rw;
  assign MemWriteM   = m_q.mw;
  assign MemStrobeM  = m_q.ms;
  assign ResultSrcM  = m_q.rs;
  assign RdM         = m_q.rd;
  assign RegWriteW   = w_q.rw;
  assign ResultSrcW  = w_q.rs;
  assign RdW         = w_q.rd;
  assign RetireCnt   = cnt_q;
endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Carries the decoder's control bundle and destination register from Decode through the Execute, Memory and Writeback stages of the RV32I pipeline.
- Converts hazard-unit stall and flush requests into held stages or bubbles, and computes the taken-branch/jump redirect in Execute.
- Exposes per-stage RegWrite, Rd and ResultSrc to the hazard unit for forwarding and load-use detection.
- Keeps a retired-instruction counter.

Parameters:
- RD_W, 5, destination register index width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ValidD  in  1  Decode holds a real instruction.
- RegWriteD  in  1  decoder RegWrite.
- ResultSrcD  in  2  decoder ResultSrc.
- MemWriteD  in  1  decoder MemWrite.
- JumpD  in  1  decoder Jump.
- BranchD  in  1  decoder Branch.
- ALUControlD  in  4  decoder ALUControl.
- ALUSrcD  in  1  decoder ALUSrc.
- MemStrobeD  in  2  decoder MemStrobe.
- RdD  in  RD_W  destination register of the Decode instruction.
- StallE  in  1  hold the ID/EX register.
- FlushE  in  1  load a bubble into ID/EX.
- BranchTakenE  in  1  branch condition result from the Execute comparator.
- ALUControlE  out  4  Execute ALU operation.
- ALUSrcE  out  1  Execute operand select.
- ResultSrcE  out  2  Execute result select; hazard unit uses bit 0 for load-use detection.
- RdE  out  RD_W  Execute destination register.
- PCSrcE  out  1  redirect the PC.
- RegWriteM  out  1  Memory-stage RegWrite.
- MemWriteM  out  1  Memory-stage MemWrite.
- MemStrobeM  out  2  Memory-stage strobe.
- ResultSrcM  out  2  Memory-stage result select.
- RdM  out  RD_W  Memory-stage destination register.
- RegWriteW  out  1  Writeback-stage RegWrite.
- ResultSrcW  out  2  Writeback-stage result select.
- RdW  out  RD_W  Writeback-stage destination register.
- RetireCnt  out  CNT_W  count of instructions retired.

Behaviour:
- Reset: while rst is high, every stage register is cleared asynchronously: valid bits, control fields, Rd fields and RetireCnt all go to 0. All outputs are therefore 0, including PCSrcE. Reset asserted mid-operation discards every in-flight instruction, and stages resume from bubbles.
- Stages: three registers, ID/EX, EX/MEM and MEM/WB. Each stores a valid bit plus the control fields the stage still needs. Latency from a D input to its E copy is 1 cycle, to M is 2 cycles, to W is 3 cycles.
- ID/EX update, priority order:
  - FlushE=1: ValidE and every control and Rd field cleared to 0. Flush wins over StallE.
  - else StallE=1: hold current contents.
  - else: capture all D inputs. ValidD=0 is captured as a bubble, with control fields forced to 0.
- EX/MEM and MEM/WB: advance every cycle and never stall. When StallE=1 and FlushE=0, EX/MEM captures a bubble so the held instruction is not duplicated downstream.
- Bubble rule: any stage whose valid bit is 0 drives RegWrite=0, MemWrite=0, Jump=0 and Branch=0. Rd and the remaining fields are also 0.
- Redirect: PCSrcE = ValidE & (JumpE | (BranchE & BranchTakenE)). It is combinational from ID/EX state and BranchTakenE, and never depends on D inputs. The block does not flush itself on PCSrcE; the hazard unit returns FlushE.
- Retire counter: increments by 1 on each rising edge where ValidW=1. It wraps from all-ones to 0 with no sticky flag.
- Simultaneous events: FlushE together with StallE behaves as a flush. PCSrcE is computed from the current E contents in the same cycle that FlushE clears them on the next edge.
- Memory-stage fields: MemStrobeM and MemWriteM are copied unchanged. Rd=0 with RegWrite=1 is passed through unmodified; x0 suppression belongs to the register file.

Test Plan:
- Reset then straight-line stream: issue add (RegWriteD=1, RdD=5, ValidD=1) then sw (MemWriteD=1, MemStrobeD=2'b10) -> RegWriteE=1 at cycle 1, RegWriteM=1 with RdM=5 at cycle 2, RegWriteW=1 at cycle 3; MemWriteM=1 with MemStrobeM=2'b10 one cycle later; RetireCnt=2 after 5 edges.
- Load-use stall: lw (ResultSrcD=2'b01, RdD=3) in E, StallE=1 for one cycle -> E holds lw (ResultSrcE=2'b01); a bubble enters M (RegWriteM=0); RetireCnt does not count the bubble.
- Taken branch: BranchD=1 reaches E with BranchTakenE=1 -> PCSrcE=1 that cycle. With BranchTakenE=0, PCSrcE=0. With JumpD=1, PCSrcE=1 regardless of BranchTakenE.
- Flush over stall: FlushE=1 and StallE=1 together with a valid jal in D -> next cycle ValidE=0, PCSrcE=0, RdE=0.
- Counter wrap: CNT_W=4, retire 17 valid instructions -> RetireCnt reads 1.
- Mid-stream reset: assert rst asynchronously between edges with three valid instructions in flight -> all outputs read 0 immediately. After release, the next instruction appears in W exactly 3 cycles after entering D.
